top2_arbiter: RTL and testbench

Round-robin scheduler that shares one top-two tracker datapath between `NREQ` requesters. Each requester submits a frame of unsigned `N`-bit values over a valid/ready stream terminated by `last`. The arbiter grants one whole frame at a time, feeds it through the embedded tracker, and returns the highest and second-highest values, tagged with the requester id, on a result handshake. It sits between the value sources and the result consumer in the second-highest-number design.

---
 rtl/top2_pkg.sv | 19 +
 rtl/top2_tracker.sv | 56 +++++
 rtl/top2_arbiter.sv | 157 +++++++++++++++
 tb/tb_top2_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top2_pkg.sv
// rtl/top2_pkg.sv - shared state type, default widths and id-width helper for the top-two arbiter
package top2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        RESULT = 2'd2
    } top2_state_t;

    localparam int TOP2_N       = 32;
    localparam int TOP2_NREQ    = 4;
    localparam int TOP2_CNT_W   = 16;
    localparam int TOP2_TIMEOUT = 64;

    function automatic int top2_id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/top2_tracker.sv
// rtl/top2_tracker.sv - running maximum / strictly-lower second maximum and saturating beat count
module top2_tracker
    import top2_pkg::*;
#(
    parameter int N     = TOP2_N,
    parameter int CNT_W = TOP2_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             beat_i,
    input  logic [N-1:0]     data_i,
    output logic [N-1:0]     hi_o,
    output logic [N-1:0]     second_o,
    output logic             second_valid_o,
    output logic [CNT_W-1:0] count_o
);

    logic [N-1:0]     hi_q;
    logic [N-1:0]     second_q;
    logic             second_valid_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q           <= '0;
            second_q       <= '0;
            second_valid_q <= 1'b0;
            count_q        <= '0;
        end else if (clear_i) begin
            hi_q           <= '0;
            second_q       <= '0;
            second_valid_q <= 1'b0;
            count_q        <= '0;
        end else if (beat_i) begin
            if (count_q != '1) begin
                count_q <= count_q + CNT_W'(1);
            end
            // The old maximum only counts as a real value once a beat has been seen.
            if (data_i > hi_q) begin
                second_q       <= hi_q;
                second_valid_q <= (count_q != '0);
                hi_q           <= data_i;
            end else if ((data_i < hi_q) && (!second_valid_q || (data_i > second_q))) begin
                second_q       <= data_i;
                second_valid_q <= 1'b1;
            end
        end
    end

    assign hi_o           = hi_q;
    assign second_o       = second_q;
    assign second_valid_o = second_valid_q;
    assign count_o        = count_q;

endmodule

// File: rtl/top2_arbiter.sv
// rtl/top2_arbiter.sv - round-robin frame scheduler around one top-two tracker; TOP2_TIMEOUT_EN adds a stall watchdog
module top2_arbiter
    import top2_pkg::*;
#(
    parameter int N              = TOP2_N,
    parameter int NREQ           = TOP2_NREQ,
    parameter int CNT_W          = TOP2_CNT_W,
    parameter int TIMEOUT_CYCLES = TOP2_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*N-1:0]        req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [N-1:0]             res_highest,
    output logic [N-1:0]             res_second,
    output logic                     res_second_valid,
    output logic [CNT_W-1:0]         res_count,
    output logic                     res_abort
);

    localparam int ID_W = top2_id_w(NREQ);

    top2_state_t     state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] rr_pick;
    logic            rr_found;
    logic            beat;
    logic            trk_clear;
    logic [N-1:0]    beat_data;

`ifdef TOP2_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               abort_q, abort_d;
`endif

    // First asserted valid after the previous owner, wrapping around.
    always_comb begin
        rr_pick  = ptr_q;
        rr_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!rr_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
                rr_pick  = ID_W'((int'(ptr_q) + k) % NREQ);
                rr_found = 1'b1;
            end
        end
    end

    assign beat      = (state_q == STREAM) && req_valid[grant_q];
    assign beat_data = req_data[grant_q*N +: N];

    always_comb begin
        req_ready = '0;
        if (state_q == STREAM) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        trk_clear = 1'b0;
`ifdef TOP2_TIMEOUT_EN
        stall_d   = stall_q;
        abort_d   = abort_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d   = rr_pick;
                    trk_clear = 1'b1;
                    state_d   = STREAM;
`ifdef TOP2_TIMEOUT_EN
                    stall_d   = '0;
                    abort_d   = 1'b0;
`endif
                end
            end
            STREAM: begin
                if (beat && req_last[grant_q]) begin
                    state_d = RESULT;
                end
`ifdef TOP2_TIMEOUT_EN
                // Ready is held high in STREAM, so a missing beat means the owner stalled.
                if (beat) begin
                    stall_d = '0;
                end else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                    stall_d = '0;
                    abort_d = 1'b1;
                    state_d = RESULT;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            RESULT: begin
                if (res_ready) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ID_W'(NREQ - 1);
`ifdef TOP2_TIMEOUT_EN
            stall_q <= '0;
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
`ifdef TOP2_TIMEOUT_EN
            stall_q <= stall_d;
            abort_q <= abort_d;
`endif
        end
    end

    top2_tracker #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear_i        (trk_clear),
        .beat_i         (beat),
        .data_i         (beat_data),
        .hi_o           (res_highest),
        .second_o       (res_second),
        .second_valid_o (res_second_valid),
        .count_o        (res_count)
    );

    assign res_valid = (state_q == RESULT);
    assign res_id    = grant_q;

`ifdef TOP2_TIMEOUT_EN
    assign res_abort = abort_q;
`else
    assign res_abort = 1'b0;
`endif

endmodule

// File: tb/tb_top2_arbiter.sv
// tb/tb_top2_arbiter.sv - randomized and directed bench for top2_arbiter against a frame-level model
module tb_top2_arbiter;

    localparam int N     = 32;
    localparam int NREQ  = 4;
    localparam int CNT_W = 3;
    localparam int TMO   = 8;
    localparam int MAXF  = 4;
    localparam int MAXL  = 10;
`ifdef TOP2_TIMEOUT_EN
    localparam int STALL_PCT = 0;
`else
    localparam int STALL_PCT = 25;
`endif

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*N-1:0]       req_data;
    logic [NREQ-1:0]         req_last;
    logic [NREQ-1:0]         req_ready;
    logic                    res_valid;
    logic                    res_ready;
    logic [$clog2(NREQ)-1:0] res_id;
    logic [N-1:0]            res_highest;
    logic [N-1:0]            res_second;
    logic                    res_second_valid;
    logic [CNT_W-1:0]        res_count;
    logic                    res_abort;

    always #5 clk = ~clk;

    top2_arbiter #(
        .N              (N),
        .NREQ           (NREQ),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_id           (res_id),
        .res_highest      (res_highest),
        .res_second       (res_second),
        .res_second_valid (res_second_valid),
        .res_count        (res_count),
        .res_abort        (res_abort)
    );

    int total = 0;
    int bad   = 0;
    int mptr;
    int id_log[$];
    int nfr[NREQ];
    int flen[NREQ][MAXF];
    logic [N-1:0] fdat[NREQ][MAXF][MAXL];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mptr    = NREQ - 1;
    endtask

    task automatic clear_frames();
        for (int i = 0; i < NREQ; i++) nfr[i] = 0;
    endtask

    // Frame summary straight from the value list.
    task automatic calc(input int id, input int f, output logic [N-1:0] hi, output logic [N-1:0] sec,
                        output logic sv, output int cnt);
        hi  = '0;
        sec = '0;
        sv  = 1'b0;
        for (int b = 0; b < flen[id][f]; b++)
            if (fdat[id][f][b] > hi) hi = fdat[id][f][b];
        for (int b = 0; b < flen[id][f]; b++)
            if (fdat[id][f][b] < hi && (!sv || fdat[id][f][b] > sec)) begin
                sec = fdat[id][f][b];
                sv  = 1'b1;
            end
        cnt = (flen[id][f] > (2**CNT_W - 1)) ? (2**CNT_W - 1) : flen[id][f];
    endtask

    task automatic run_frames(input int stall_pct, input int rdy_pct, input int hold_cycles,
                              output int first_lat);
        int fidx[NREQ];
        int bidx[NREQ];
        int mdone[NREQ];
        int remaining, cyc, held, eid, ecnt;
        logic [N-1:0] ehi, esec;
        logic esv, in_res;
        logic [NREQ-1:0] acc;
        remaining = 0;
        for (int i = 0; i < NREQ; i++) begin
            fidx[i] = 0; bidx[i] = 0; mdone[i] = 0;
            remaining += nfr[i];
        end
        cyc = 0; held = 0; eid = 0; ecnt = 0; in_res = 1'b0; first_lat = -1;
        ehi = '0; esec = '0; esv = 1'b0;
        id_log.delete();
        while (remaining > 0 && cyc < 4000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (fidx[i] < nfr[i]) begin
                    req_valid[i] = !(req_ready[i] && ($urandom_range(0, 99) < stall_pct));
                    req_data[i*N +: N] = fdat[i][fidx[i]][bidx[i]];
                    req_last[i] = (bidx[i] == flen[i][fidx[i]] - 1);
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                    req_data[i*N +: N] = N'($urandom);
                end
            end
            if (res_valid && held < hold_cycles) begin
                res_ready = 1'b0;
                held++;
            end else begin
                res_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            @(negedge clk);
            if (res_valid) begin
                if (!in_res) begin
                    in_res = 1'b1;
                    if (first_lat < 0) first_lat = cyc;
                    eid = -1;
                    for (int k = 1; k <= NREQ; k++)
                        if (eid < 0 && mdone[(mptr + k) % NREQ] < nfr[(mptr + k) % NREQ])
                            eid = (mptr + k) % NREQ;
                    if (eid < 0) begin
                        check_eq("spurious_res", 64'(res_valid), 64'd0);
                        return;
                    end
                    calc(eid, mdone[eid], ehi, esec, esv, ecnt);
                end
                check_eq("res_id", 64'(res_id), 64'(eid));
                check_eq("res_highest", 64'(res_highest), 64'(ehi));
                check_eq("res_second", 64'(res_second), 64'(esec));
                check_eq("res_second_valid", 64'(res_second_valid), 64'(esv));
                check_eq("res_count", 64'(res_count), 64'(ecnt));
                check_eq("res_abort", 64'(res_abort), 64'd0);
                check_eq("ready_in_result", 64'(req_ready), 64'd0);
                if (res_ready) begin
                    id_log.push_back(int'(res_id));
                    mdone[eid]++;
                    mptr = eid;
                    remaining--;
                    in_res = 1'b0;
                end
            end
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < NREQ; i++)
                if (acc[i]) begin
                    if (bidx[i] == flen[i][fidx[i]] - 1) begin
                        fidx[i]++;
                        bidx[i] = 0;
                    end else begin
                        bidx[i]++;
                    end
                end
        end
        check_eq("engine_budget", 64'(remaining), 64'd0);
        req_valid = '0;
        req_last  = '0;
        res_ready = 1'b0;
    endtask

    initial begin
        int lat, b, wc;
        int expo[5];
        do_reset();
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_res_id", 64'(res_id), 64'd0);
        check_eq("rst_highest", 64'(res_highest), 64'd0);
        check_eq("rst_second", 64'(res_second), 64'd0);
        check_eq("rst_second_valid", 64'(res_second_valid), 64'd0);
        check_eq("rst_count", 64'(res_count), 64'd0);
        check_eq("rst_abort", 64'(res_abort), 64'd0);

        // Requester 1: 5 9 3 9 7
        clear_frames();
        nfr[1] = 1; flen[1][0] = 5;
        fdat[1][0][0] = 5; fdat[1][0][1] = 9; fdat[1][0][2] = 3; fdat[1][0][3] = 9; fdat[1][0][4] = 7;
        run_frames(0, 100, 0, lat);
        check_eq("first_latency", 64'(lat), 64'd6);

        // Requester 0: two all-ones beats
        clear_frames();
        nfr[0] = 1; flen[0][0] = 2;
        fdat[0][0][0] = 32'hFFFF_FFFF; fdat[0][0][1] = 32'hFFFF_FFFF;
        run_frames(0, 100, 0, lat);

        // All four requesters contend; requester 0 has a second frame
        do_reset();
        clear_frames();
        for (int i = 0; i < NREQ; i++) begin
            nfr[i] = (i == 0) ? 2 : 1;
            for (int f = 0; f < nfr[i]; f++) begin
                flen[i][f] = 2;
                fdat[i][f][0] = N'(i * 16 + f + 3);
                fdat[i][f][1] = N'(i * 16 + f + 1);
            end
        end
        run_frames(0, 100, 0, lat);
        expo = '{0, 1, 2, 3, 0};
        check_eq("order_len", 64'(id_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < id_log.size(); k++)
            check_eq($sformatf("order%0d", k), 64'(id_log[k]), 64'(expo[k]));

        // Backpressure for 10 cycles on a saturating 9-beat frame
        clear_frames();
        nfr[3] = 1; flen[3][0] = 9;
        for (int j = 0; j < 9; j++) fdat[3][0][j] = N'(j + 1);
        run_frames(0, 100, 10, lat);
        check_eq("post_hs_res_valid", 64'(res_valid), 64'd0);
        check_eq("post_hs_req_ready", 64'(req_ready), 64'd0);

        // Reset after three beats of a six-beat frame
        do_reset();
        req_valid = 4'b0100;
        b = 0; wc = 0;
        while (b < 3 && wc < 20) begin
            logic a;
            req_data[2*N +: N] = N'(b + 10);
            req_last[2] = 1'b0;
            @(negedge clk);
            a = req_valid[2] & req_ready[2];
            @(posedge clk);
            #1;
            wc++;
            if (a) b++;
        end
        check_eq("mid_beats", 64'(b), 64'd3);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("mid_rst_count", 64'(res_count), 64'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mptr = NREQ - 1;
        clear_frames();
        nfr[0] = 1; flen[0][0] = 3;
        fdat[0][0][0] = 2; fdat[0][0][1] = 8; fdat[0][0][2] = 8;
        nfr[2] = 1; flen[2][0] = 6;
        for (int j = 0; j < 6; j++) fdat[2][0][j] = N'(j + 10);
        run_frames(0, 100, 0, lat);
        check_eq("rst_order_len", 64'(id_log.size()), 64'd2);
        if (id_log.size() > 0) check_eq("rst_first_grant", 64'(id_log[0]), 64'd0);

`ifdef TOP2_TIMEOUT_EN
        do_reset();
        req_valid = 4'b0001;
        req_last  = '0;
        b = 0; wc = 0;
        while (b < 2 && wc < 20) begin
            logic a;
            req_data[0 +: N] = (b == 0) ? N'(4) : N'(6);
            @(negedge clk);
            a = req_valid[0] & req_ready[0];
            @(posedge clk);
            #1;
            wc++;
            if (a) b++;
        end
        req_valid = '0;
        wc = 0;
        while (!res_valid && wc < 30) begin
            @(posedge clk);
            #1;
            wc++;
        end
        check_eq("tmo_cycles", 64'(wc), 64'(TMO));
        check_eq("tmo_abort", 64'(res_abort), 64'd1);
        check_eq("tmo_highest", 64'(res_highest), 64'd6);
        check_eq("tmo_second", 64'(res_second), 64'd4);
        check_eq("tmo_second_valid", 64'(res_second_valid), 64'd1);
        check_eq("tmo_count", 64'(res_count), 64'd2);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_eq("tmo_release", 64'(res_valid), 64'd0);
        mptr = 0;
`endif

        for (int r = 0; r < 6; r++) begin
            int tot;
            clear_frames();
            tot = 0;
            for (int i = 0; i < NREQ; i++) begin
                nfr[i] = $urandom_range(0, 3);
                tot += nfr[i];
                for (int f = 0; f < nfr[i]; f++) begin
                    flen[i][f] = $urandom_range(1, MAXL);
                    for (int j = 0; j < flen[i][f]; j++)
                        case ($urandom_range(0, 3))
                            0: fdat[i][f][j] = N'($urandom_range(0, 5));
                            1: fdat[i][f][j] = N'($urandom);
                            2: fdat[i][f][j] = 32'hFFFF_FFFF;
                            default: fdat[i][f][j] = N'($urandom_range(0, 2));
                        endcase
                end
            end
            if (tot == 0) begin
                nfr[0] = 1; flen[0][0] = 1; fdat[0][0][0] = N'($urandom);
            end
            run_frames(STALL_PCT, 60, 0, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
